i3c_cmd_sequencer: RTL and testbench
====================================

# i3c_cmd_sequencer

Upstream command stage for `i3c_controller`. It buffers host transfer commands in a small FIFO and issues them one at a time on the controller's `device_address`/`start_transfer`/`is_read`/`write_data` control interface. It then waits for `transfer_complete` or `error` and posts one response per command into a response FIFO. A watchdog converts a hung controller into an error response, so the host never stalls.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `RSP_DEPTH`, 4: response FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: maximum cycles in WAIT before a timeout response; ≥2.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cmd_valid_i`  in  1  host command valid.
- `cmd_ready_o`  out  1  command FIFO not full.
- `cmd_rnw_i`  in  1  1 = read, 0 = write.
- `cmd_addr_i`  in  `ADDR_WIDTH`  7-bit target address.
- `cmd_wdata_i`  in  `DATA_WIDTH`  write byte (ignored for reads).
- `rsp_valid_o`  out  1  response FIFO not empty.
- `rsp_ready_i`  in  1  host pops a response.
- `rsp_rdata_o`  out  `DATA_WIDTH`  read byte; 0 for writes and for errors.
- `rsp_err_o`  out  1  transfer failed (controller error or timeout).
- `rsp_timeout_o`  out  1  failure was a watchdog timeout.
- `device_address_o`  out  `ADDR_WIDTH`  to controller `device_address`.
- `start_transfer_o`  out  1  one-cycle start pulse.
- `is_read_o`  out  1  to controller `is_read`.
- `write_data_o`  out  `DATA_WIDTH`  to controller `write_data`.
- `read_data_i`  in  `DATA_WIDTH`  from controller `read_data`.
- `transfer_complete_i`  in  1  from controller; level or pulse.
- `error_i`  in  1  from controller; level or pulse.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- **Command accept:** a command is pushed on `cmd_valid_i && cmd_ready_o`. The entry is `{rnw, addr, wdata}`.
- **Completion detection:** the block registers the previous values of `transfer_complete_i` and `error_i`. Completion is the rising edge of either (current=1, previous=0). Edges outside WAIT are ignored.
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when the command FIFO is non-empty and the response FIFO has at least one free slot. The slot is reserved, so a response write can never overflow.
  - ISSUE (one cycle):
    - pop the command;
    - load `device_address_o`/`is_read_o`/`write_data_o`;
    - assert `start_transfer_o`;
    - clear the watchdog;
    - go to WAIT.
  - WAIT:
    - `device_address_o`/`is_read_o`/`write_data_o` stay stable.
    - The watchdog increments each cycle.
    - On a completion edge, write the response and go to IDLE.
  - Watchdog expiry: if the watchdog reaches `TIMEOUT_CYCLES-1` with no edge, write `{err=1, timeout=1, rdata=0}` and go to IDLE.
- **Response contents:**
  - Rising `error_i`: `err=1, timeout=0, rdata=0`.
  - Rising `transfer_complete_i` only: `err=0`; `rdata = read_data_i` sampled that cycle if the command was a read, else 0.
- **Simultaneous events:**
  - Complete and error edges in the same cycle: error wins.
  - Completion edge in the watchdog expiry cycle: completion wins (no timeout).
  - Push and pop on the same cycle on either FIFO: both occur and the count is unchanged.
  - Push when full is blocked by `cmd_ready_o=0`. Pop when empty is ignored.
- **FIFO pointers:** wrap modulo depth, with an extra wrap bit for full/empty.
- **Reset (`rst_i`=1, any state, including mid-transfer):** next edge gives
  - FSM IDLE, both FIFOs empty;
  - all outputs 0;
  - the in-flight command is abandoned with no response;
  - `cmd_ready_o`=0 while `rst_i`=1, and 1 from the first cycle after.

## Timing
- Command pushed into an empty FIFO at edge N (sequencer idle): ISSUE at cycle N+1, `start_transfer_o`=1 during cycle N+1 only.
- Completion edge seen in cycle M: response written at edge M+1; `rsp_valid_o`=1 in cycle M+1.
- Back-to-back commands: next `start_transfer_o` no earlier than 2 cycles after the completion edge cycle.
- `rsp_*_o` are FIFO head outputs, valid whenever `rsp_valid_o`=1. The head is held until `rsp_ready_i` is sampled high.
- Watchdog width: `$clog2(TIMEOUT_CYCLES)`. Timeout response no earlier than `TIMEOUT_CYCLES` cycles after ISSUE.

## Structure
- Shared package / `i3c_params.vh` gains:
  - `SEQ_IDLE`/`SEQ_ISSUE`/`SEQ_WAIT` encodings;
  - `CMD_W` = 1+`ADDR_WIDTH`+`DATA_WIDTH`;
  - `RSP_W` = 2+`DATA_WIDTH`.
- Reuse the existing `ADDR_WIDTH`/`DATA_WIDTH`.
- One sub-module: `i3c_sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty/count). Instantiated twice, for commands and responses.

## Test plan
- **Write:**
  - Stimulus: push write `addr=0x50`, `wdata=0xA5`.
  - Response: one-cycle `start_transfer_o` with `device_address_o=0x50`, `write_data_o=0xA5`, `is_read_o=0`. Pulse `transfer_complete_i` 20 cycles later → response `err=0, rdata=0x00`.
- **Read:**
  - Stimulus: push read `addr=0x51`; model returns `read_data_i=0x3C` with a level-high `transfer_complete_i`.
  - Response: response `rdata=0x3C, err=0`. A second queued command issues once the level drops and rises again.
- **Backpressure:**
  - Stimulus: push 5 commands with `CMD_DEPTH=4` and `rsp_ready_i=0`.
  - Response: `cmd_ready_o`=0 after the FIFO fills. Issue stalls after `RSP_DEPTH` responses are outstanding. Popping responses resumes issue; all 5 responses come out in order.
- **Error:**
  - Stimulus: rising `error_i`, together with `transfer_complete_i` in the same cycle.
  - Response: `err=1, timeout=0, rdata=0`.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES=16`, no completion.
  - Response: `err=1, timeout=1` written at cycle ISSUE+16. The next command then issues normally.
- **Reset:**
  - Stimulus: `rst_i` pulse during WAIT with 2 commands queued.
  - Response: FIFOs empty, `rsp_valid_o=0`, no `start_transfer_o` afterwards. A later completion edge produces no response.

Source files
------------

// File: rtl/i3c_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// i3c_cmd_sequencer_pkg : shared widths and FSM encodings for the sequencer
// Rev 1.0
// ============================================================================
package i3c_cmd_sequencer_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;
    localparam int CMD_W      = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int RSP_W      = 2 + DATA_WIDTH;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/i3c_sync_fifo.sv
`default_nettype none
// ============================================================================
// i3c_sync_fifo : single-clock FIFO with wrap-bit pointers, head-of-queue read
// Rev 1.0
// ============================================================================
module i3c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_push;
    logic             w_pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/i3c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// i3c_cmd_sequencer : queues host commands, issues them to i3c_controller one
//                     at a time and returns one response each, with watchdog
// Rev 1.0
// ============================================================================
module i3c_cmd_sequencer
    import i3c_cmd_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rnw_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] device_address_o,
    output logic                  start_transfer_o,
    output logic                  is_read_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic                  transfer_complete_i,
    input  logic                  error_i,
    output logic                  busy_o
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    seq_state_e              state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rnw_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    start_q;
    logic [WDOG_W-1:0]       wdog_q;
    logic                    tc_prev_q;
    logic                    err_prev_q;

    logic                    w_cmd_push;
    logic                    w_cmd_pop;
    logic [CMD_W-1:0]        w_cmd_head;
    logic                    w_cmd_full;
    logic                    w_cmd_empty;
    logic [$clog2(CMD_DEPTH):0] w_unused_cmd_count;

    logic                    w_rsp_push;
    logic [RSP_W-1:0]        w_rsp_wdata;
    logic [RSP_W-1:0]        w_rsp_head;
    logic                    w_rsp_full;
    logic                    w_rsp_empty;
    logic [$clog2(RSP_DEPTH):0] w_unused_rsp_count;

    logic                    w_tc_edge;
    logic                    w_err_edge;
    logic                    w_expire;

    assign cmd_ready_o = !rst_i && !w_cmd_full;
    assign w_cmd_push  = cmd_valid_i && cmd_ready_o;
    assign w_cmd_pop   = (state_q == SEQ_ISSUE);

    i3c_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_cmd_push),
        .wdata_i ({cmd_rnw_i, cmd_addr_i, cmd_wdata_i}),
        .pop_i   (w_cmd_pop),
        .rdata_o (w_cmd_head),
        .full_o  (w_cmd_full),
        .empty_o (w_cmd_empty),
        .count_o (w_unused_cmd_count)
    );

    assign w_tc_edge  = transfer_complete_i && !tc_prev_q;
    assign w_err_edge = error_i && !err_prev_q;
    assign w_expire   = (wdog_q == WDOG_LAST);
    assign w_rsp_push = (state_q == SEQ_WAIT) && (w_tc_edge || w_err_edge || w_expire);

    // Priority: controller error, then completion, then watchdog expiry.
    always_comb begin
        w_rsp_wdata = {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
        if (w_err_edge) begin
            w_rsp_wdata = {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
        end else if (w_tc_edge) begin
            w_rsp_wdata = {1'b0, 1'b0, (rnw_q ? read_data_i : {DATA_WIDTH{1'b0}})};
        end
    end

    i3c_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_rsp_push),
        .wdata_i (w_rsp_wdata),
        .pop_i   (rsp_ready_i),
        .rdata_o (w_rsp_head),
        .full_o  (w_rsp_full),
        .empty_o (w_rsp_empty),
        .count_o (w_unused_rsp_count)
    );

    assign rsp_valid_o   = !w_rsp_empty;
    assign rsp_err_o     = rsp_valid_o && w_rsp_head[RSP_W-1];
    assign rsp_timeout_o = rsp_valid_o && w_rsp_head[RSP_W-2];
    assign rsp_rdata_o   = rsp_valid_o ? w_rsp_head[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};

    assign device_address_o = addr_q;
    assign is_read_o        = rnw_q;
    assign write_data_o     = wdata_q;
    assign start_transfer_o = start_q;
    assign busy_o           = (state_q != SEQ_IDLE);

    // Leaving IDLE requires a free response slot; with one transfer in flight
    // that slot stays reserved until the response is written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEQ_IDLE;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            wdata_q    <= '0;
            start_q    <= 1'b0;
            wdog_q     <= '0;
            tc_prev_q  <= 1'b0;
            err_prev_q <= 1'b0;
        end else begin
            tc_prev_q  <= transfer_complete_i;
            err_prev_q <= error_i;
            start_q    <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (!w_cmd_empty && !w_rsp_full) begin
                        state_q                   <= SEQ_ISSUE;
                        start_q                   <= 1'b1;
                        {rnw_q, addr_q, wdata_q}  <= w_cmd_head;
                    end
                end
                SEQ_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (w_rsp_push) begin
                        state_q <= SEQ_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i3c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_i3c_cmd_sequencer : directed self-checking bench for i3c_cmd_sequencer
// Rev 1.0
// ============================================================================
module tb_i3c_cmd_sequencer;

    localparam int TO = 32;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rnw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [6:0] dev_addr;
    logic       start;
    logic       is_read;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       tc;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    i3c_cmd_sequencer #(
        .CMD_DEPTH      (4),
        .RSP_DEPTH      (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_rnw_i           (cmd_rnw),
        .cmd_addr_i          (cmd_addr),
        .cmd_wdata_i         (cmd_wdata),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_rdata_o         (rsp_rdata),
        .rsp_err_o           (rsp_err),
        .rsp_timeout_o       (rsp_timeout),
        .device_address_o    (dev_addr),
        .start_transfer_o    (start),
        .is_read_o           (is_read),
        .write_data_o        (wr_data),
        .read_data_i         (rd_data),
        .transfer_complete_i (tc),
        .error_i             (err),
        .busy_o              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic rnw, input logic [6:0] addr, input logic [7:0] wdata);
        int k;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (start !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("start_seen", {31'd0, start}, 32'd1);
    endtask

    task automatic pulse_done(input logic [7:0] data);
        rd_data = data;
        tc      = 1'b1;
        tick();
        tc      = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic e, input logic t, input logic [7:0] d);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
        chk({tag, "_tmo"}, {31'd0, rsp_timeout}, {31'd0, t});
        chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, d});
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; rd_data = '0; tc = 1'b0; err = 1'b0;
        tick(2);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_addr", {25'd0, dev_addr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Write: start one cycle after the push, response after the pulse.
        push_cmd(1'b0, 7'h50, 8'hA5);
        chk("wr_idle_start", {31'd0, start}, 32'd0);
        tick();
        chk("wr_start", {31'd0, start}, 32'd1);
        chk("wr_addr", {25'd0, dev_addr}, 32'h50);
        chk("wr_data", {24'd0, wr_data}, 32'hA5);
        chk("wr_isread", {31'd0, is_read}, 32'd0);
        tick();
        chk("wr_start_once", {31'd0, start}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        tick(19);
        chk("wr_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        chk("wr_addr_stable", {25'd0, dev_addr}, 32'h50);
        pulse_done(8'h77);
        check_rsp("wr_rsp", 1'b0, 1'b0, 8'h00);
        pop_rsp();
        chk("wr_popped", {31'd0, rsp_valid}, 32'd0);

        // Read with level completion, then a second queued command.
        push_cmd(1'b1, 7'h51, 8'h00);
        push_cmd(1'b0, 7'h52, 8'h11);
        wait_start();
        chk("rd_addr", {25'd0, dev_addr}, 32'h51);
        chk("rd_isread", {31'd0, is_read}, 32'd1);
        tick(3);
        rd_data = 8'h3C;
        tc = 1'b1;
        tick();
        check_rsp("rd_rsp", 1'b0, 1'b0, 8'h3C);
        pop_rsp();
        wait_start();
        chk("rd2_addr", {25'd0, dev_addr}, 32'h52);
        chk("rd2_isread", {31'd0, is_read}, 32'd0);
        tick(4);
        chk("rd2_level_ignored", {31'd0, rsp_valid}, 32'd0);
        tc = 1'b0;
        tick();
        tc = 1'b1;
        tick();
        check_rsp("rd2_rsp", 1'b0, 1'b0, 8'h00);
        tc = 1'b0;
        pop_rsp();

        // Backpressure: five reads, responses held back.
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 7'(32'h60 + i), 8'h00);
        chk("bp_cmd_full", {31'd0, cmd_ready}, 32'd0);
        pulse_done(8'h80);
        for (int i = 1; i < 4; i++) begin
            wait_start();
            tick();
            pulse_done(8'(32'h80 + i));
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (start === 1'b1) seen = 1'b1;
            tick();
        end
        chk("bp_stalled", {31'd0, seen}, 32'd0);
        chk("bp_idle", {31'd0, busy}, 32'd0);
        chk("bp_cmd_room", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_rsp("bp_rsp", 1'b0, 1'b0, 8'(32'h80 + i));
            pop_rsp();
        end
        chk("bp_resumed_addr", {25'd0, dev_addr}, 32'h64);
        chk("bp_resumed_busy", {31'd0, busy}, 32'd1);
        pulse_done(8'h84);
        check_rsp("bp_rsp4", 1'b0, 1'b0, 8'h84);
        pop_rsp();
        chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

        // Error and completion rising together: error wins.
        push_cmd(1'b1, 7'h70, 8'h00);
        wait_start();
        tick();
        rd_data = 8'hFF;
        tc = 1'b1;
        err = 1'b1;
        tick();
        tc = 1'b0;
        err = 1'b0;
        check_rsp("err_rsp", 1'b1, 1'b0, 8'h00);
        pop_rsp();

        // Watchdog: no completion at all.
        push_cmd(1'b1, 7'h71, 8'h00);
        wait_start();
        tick(TO);
        chk("tmo_not_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_rsp("tmo_rsp", 1'b1, 1'b1, 8'h00);
        pop_rsp();
        push_cmd(1'b0, 7'h72, 8'h5A);
        wait_start();
        chk("tmo_next_addr", {25'd0, dev_addr}, 32'h72);
        chk("tmo_next_data", {24'd0, wr_data}, 32'h5A);
        tick();
        pulse_done(8'h00);
        check_rsp("tmo_next_rsp", 1'b0, 1'b0, 8'h00);
        pop_rsp();

        // Reset mid-transfer with two commands queued.
        push_cmd(1'b0, 7'h30, 8'h01);
        push_cmd(1'b0, 7'h31, 8'h02);
        push_cmd(1'b0, 7'h32, 8'h03);
        tick(2);
        chk("rst2_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst2_ready_low", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("rst2_addr", {25'd0, dev_addr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst2_ready", {31'd0, cmd_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (start === 1'b1) seen = 1'b1;
            tick();
        end
        chk("rst2_no_start", {31'd0, seen}, 32'd0);
        pulse_done(8'h00);
        tick(2);
        chk("rst2_no_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
